// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with a per-register busy scoreboard for pending writes.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [WIDTH-1:0]  wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [WIDTH-1:0]  wd1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NRD   = 2;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_busy;
  logic                        r_rsv_err;

  logic w_we0, w_we1, w_rsv, w_rsv_clr;

  // Register 0 is hardwired when ZERO_REG: gate every state-changing request aimed at it.
  function automatic logic f_live(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_we0     = we0 & f_live(wa0);
  assign w_we1     = we1 & f_live(wa1);
  assign w_rsv     = rsv_en & f_live(rsv_addr);
  assign w_rsv_clr = (w_we0 && (wa0 == rsv_addr)) || (w_we1 && (wa1 == rsv_addr));

  // Statement order encodes priority: port 1 beats port 0, reservation beats the write clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem     <= '0;
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      if (w_we0) begin
        r_mem[wa0]  <= wd0;
        r_busy[wa0] <= 1'b0;
      end
      if (w_we1) begin
        r_mem[wa1]  <= wd1;
        r_busy[wa1] <= 1'b0;
      end
      if (w_rsv) r_busy[rsv_addr] <= 1'b1;
      r_rsv_err <= w_rsv && r_busy[rsv_addr] && !w_rsv_clr;
    end
  end

  assign rsv_err = r_rsv_err;

  logic [NRD-1:0][ADDR_W-1:0] w_ra;
  logic [NRD-1:0][WIDTH-1:0]  w_rd;
  logic [NRD-1:0]             w_busy;

  assign w_ra = {ra2, ra1};

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic w_hit0, w_hit1;
    assign w_hit0    = w_we0 && (wa0 == w_ra[g]);
    assign w_hit1    = w_we1 && (wa1 == w_ra[g]);
    assign w_busy[g] = r_busy[w_ra[g]] & ~w_hit0 & ~w_hit1;
`ifdef REGFILE_BYPASS_EN
    assign w_rd[g] = w_hit1 ? wd1 : (w_hit0 ? wd0 : r_mem[w_ra[g]]);
`else
    assign w_rd[g] = r_mem[w_ra[g]];
`endif
  end

  assign rd1   = w_rd[0];
  assign rd2   = w_rd[1];
  assign busy1 = w_busy[0];
  assign busy2 = w_busy[1];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: the driver queues hand-computed expectations, a negedge monitor pops and compares.
module tb_regfile_scoreboard;
  localparam int WIDTH = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH = 2**ADDR_W;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] ra1, ra2, wa0, wa1, rsv_addr;
  logic [WIDTH-1:0]  rd1, rd2, wd0, wd1;
  logic              busy1, busy2, we0, we1, rsv_en, rsv_err;

  regfile_scoreboard #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_err(rsv_err)
  );

  always #5 clk = ~clk;

  // mask bits: [4] rd1, [3] busy1, [2] rd2, [1] busy2, [0] rsv_err
  typedef struct {
    string            name;
    logic [4:0]       mask;
    logic [WIDTH-1:0] rd1;
    logic             b1;
    logic [WIDTH-1:0] rd2;
    logic             b2;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic push(input string n, input logic [4:0] m, input logic [WIDTH-1:0] r1,
                      input logic bb1, input logic [WIDTH-1:0] r2, input logic bb2, input logic e);
    exp_t x;
    x.name = n; x.mask = m; x.rd1 = r1; x.b1 = bb1; x.rd2 = r2; x.b2 = bb2; x.err = e;
    q.push_back(x);
  endtask

  task automatic chk(input string n, input string f, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", n, f, act, exp, $time);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.mask[4]) chk(e.name, "rd1", rd1, e.rd1);
      if (e.mask[3]) chk(e.name, "busy1", {31'b0, busy1}, {31'b0, e.b1});
      if (e.mask[2]) chk(e.name, "rd2", rd2, e.rd2);
      if (e.mask[1]) chk(e.name, "busy2", {31'b0, busy2}, {31'b0, e.b2});
      if (e.mask[0]) chk(e.name, "rsv_err", {31'b0, rsv_err}, {31'b0, e.err});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we0 = 0; we1 = 0; rsv_en = 0;
  endtask

  initial begin
    rst_n = 0; ra1 = 0; ra2 = 0; wa0 = 0; wa1 = 0; rsv_addr = 0;
    wd0 = 0; wd1 = 0; we0 = 0; we1 = 0; rsv_en = 0;
    #2;
    tick;
    push("reset_hold", 5'b11111, 0, 0, 0, 0, 0);
    tick;
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = i[ADDR_W-1:0];
      ra2 = 5'(DEPTH - 1 - i);
      push("reset_sweep", 5'b11111, 0, 0, 0, 0, 0);
      tick;
    end

    we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; ra1 = 3; ra2 = 4;
    push("wr_same_cycle", 5'b11110, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0);
    tick; idle;
    push("wr_next_cycle", 5'b10000, 32'hDEADBEEF, 0, 0, 0, 0);
    tick;

    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra1 = 7;
    push("collide_same", 5'b10000, BYP ? 32'h22 : 32'h0, 0, 0, 0, 0);
    tick; idle;
    push("collide_next", 5'b10000, 32'h22, 0, 0, 0, 0);
    tick;

    rsv_en = 1; rsv_addr = 5; ra1 = 5;
    push("rsv5_issue", 5'b01000, 0, 0, 0, 0, 0);
    tick; idle;
    push("rsv5_busy", 5'b01001, 0, 1, 0, 0, 0);
    tick;
    we1 = 1; wa1 = 5; wd1 = 32'h55;
    push("rsv5_wr_cycle", 5'b01000, 0, 0, 0, 0, 0);
    tick; idle;
    push("rsv5_after", 5'b11000, 32'h55, 0, 0, 0, 0);
    tick;

    rsv_en = 1; rsv_addr = 6; we0 = 1; wa0 = 6; wd0 = 32'h66; ra2 = 6;
    tick; idle;
    push("rsv_wins_wr", 5'b00111, 0, 0, 32'h66, 1, 0);
    tick;

    rsv_en = 1; rsv_addr = 9; ra1 = 9;
    push("rsv9_first", 5'b00001, 0, 0, 0, 0, 0);
    tick;
    push("rsv9_second", 5'b00001, 0, 0, 0, 0, 0);
    tick; idle;
    push("rsv9_err", 5'b01001, 0, 1, 0, 0, 1);
    tick;
    push("rsv9_err_drop", 5'b01001, 0, 1, 0, 0, 0);
    tick;
    rsv_en = 1; rsv_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h99;
    tick; idle;
    push("rsv9_clr_noerr", 5'b11001, 32'h99, 1, 0, 0, 0);
    tick;

    we0 = 1; wa0 = 0; wd0 = 32'hFFFF; we1 = 1; wa1 = 0; wd1 = 32'hFFFF;
    rsv_en = 1; rsv_addr = 0; ra1 = 0; ra2 = 0;
    push("zero_same", 5'b11110, 0, 0, 0, 0, 0);
    tick;
    we1 = 0;
    push("zero_next", 5'b11111, 0, 0, 0, 0, 0);
    tick; idle;
    push("zero_noerr", 5'b11111, 0, 0, 0, 0, 0);
    tick;

    rsv_en = 1; rsv_addr = 12; ra1 = 12; ra2 = 3;
    tick;
    push("rsv12_busy", 5'b01100, 0, 1, 32'hDEADBEEF, 0, 0);
    tick;
    rst_n = 0; we0 = 1; wa0 = 3; wd0 = 32'h1234;
    push("rst_mid_rsv", 5'b11111, 0, 0, 0, 0, 0);
    tick;
    push("rst_discard", 5'b11111, 0, 0, 0, 0, 0);
    tick;
    idle; rst_n = 1;
    push("rst_release", 5'b11111, 0, 0, 0, 0, 0);
    tick;

    for (int k = 0; k < 100 && q.size() > 0; k++) tick;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width of every register in bits.
REQ-002 Parameter ADDR_W, default 5, sets the register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes and reservations.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Ports ra1 and ra2, input, ADDR_W bits each: read addresses.
REQ-007 Ports rd1 and rd2, output, WIDTH bits each: read data, combinational from the read addresses and state.
REQ-008 Ports busy1 and busy2, output, 1 bit each: the register at ra1 or ra2 has a pending reservation that is not being retired this cycle.
REQ-009 Ports we0, wa0 and wd0, input, 1/ADDR_W/WIDTH bits: write port 0.
REQ-010 Ports we1, wa1 and wd1, input, 1/ADDR_W/WIDTH bits: write port 1.
REQ-011 Ports rsv_en and rsv_addr, input, 1/ADDR_W bits: reservation request that marks a register as awaiting a future write.
REQ-012 Port rsv_err, output, 1 bit, registered: flags a reservation made to an already-busy register.

Function
REQ-013 Storage is DEPTH x WIDTH flops; each write port with weN=1 writes wdN to register waN at the rising clk edge.
REQ-014 Write collision: when both write ports target the same address in the same cycle, port 1 data is stored.
REQ-015 Scoreboard: each register has one busy bit; rsv_en=1 sets busy[rsv_addr] at the clock edge.
REQ-016 A write from either port to a register clears that register's busy bit at the same edge.
REQ-017 Simultaneous reservation and write to the same address: the data is written and busy ends set, because the reservation wins.
REQ-018 busyN = busy[raN] AND NOT (any weN with waN == raN in the current cycle).
REQ-019 rsv_err = 1 for exactly one cycle after an edge at which rsv_en=1 and busy[rsv_addr] was already 1 and not being cleared; busy stays set.
REQ-020 With ZERO_REG=1 and address 0: rd reads 0, busy reads 0, writes are discarded, reservations are discarded, and rsv_err never asserts.
REQ-021 Read latency is 0 cycles from the address; a write becomes visible at the reads in the cycle after its edge, unless bypass is enabled (REQ-025).
REQ-022 Addresses are never out of range because DEPTH = 2**ADDR_W; no wrap-around handling is required.

Reset
REQ-023 When rst_n=0, all registers, all busy bits and rsv_err clear to 0 asynchronously, independent of clk.
REQ-024 Reset mid-operation discards any write or reservation presented in that cycle; normal operation resumes at the first rising edge after rst_n returns to 1.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN, when defined, enables write-to-read bypass:
- rdN returns the current-cycle write data when a weN with waN == raN is active.
- Port 1 has priority on a collision.
- The ZERO_REG rule still applies.
REQ-026 When REGFILE_BYPASS_EN is undefined, rdN returns stored contents only; all other behaviour is identical.

Verification
REQ-027 Reset then read all addresses -> rd1 = rd2 = 0 and busy1 = busy2 = 0 for every address.
REQ-028 we0=1, wa0=3, wd0=0xDEADBEEF; same cycle ra1=3 -> rd1 = 0xDEADBEEF in that cycle with REGFILE_BYPASS_EN and old value 0 without it; the next cycle always reads 0xDEADBEEF.
REQ-029 we0 and we1 both target address 7 with 0x11 and 0x22 -> the next cycle rd1 = 0x22.
REQ-030 rsv_en with rsv_addr=5 -> busy1 = 1 at ra1=5; then we1, wa1=5 -> busy1 = 0 in the write cycle and afterwards.
REQ-031 Reserve 9 twice on consecutive cycles -> rsv_err = 1 for the single cycle after the second reservation, and busy stays 1.
REQ-032 ZERO_REG=1: write 0xFFFF to register 0 and reserve 0 -> rd = 0, busy = 0 and rsv_err = 0; assert rst_n mid-reservation -> busy clears immediately.
